// File: rtl/switch_event_arbiter_if.sv
// rtl/switch_event_arbiter_if.sv - switch inputs and LED/status outputs of the switch event arbiter
interface switch_event_arbiter_if;
    logic       i_Switch_1;
    logic       i_Switch_2;
    logic       i_Switch_3;
    logic       i_Switch_4;
    logic       o_LED_1;
    logic       o_LED_2;
    logic       o_LED_3;
    logic       o_LED_4;
    logic       o_Busy;
    logic [1:0] o_Grant;
    logic       o_Drop;
    logic [7:0] o_Serviced;

    modport master (
        output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        input  o_LED_1, o_LED_2, o_LED_3, o_LED_4,
        input  o_Busy, o_Grant, o_Drop, o_Serviced
    );

    modport slave (
        input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        output o_LED_1, o_LED_2, o_LED_3, o_LED_4,
        output o_Busy, o_Grant, o_Drop, o_Serviced
    );
endinterface

// File: rtl/switch_event_arbiter.sv
// rtl/switch_event_arbiter.sv - round-robin arbiter granting timed LED slots to switch release events
module switch_event_arbiter #(
    parameter int HOLD_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    switch_event_arbiter_if.slave bus
);
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       sw;
    logic [3:0]       prev_level;
    logic [3:0]       pending;
    logic [3:0]       release_evt;
    logic [3:0]       clear_mask;
    logic [3:0]       led_mask;
    logic [1:0]       grant;
    logic [1:0]       winner;
    logic             start_grant;
    logic             drop;
    logic [7:0]       serviced;

    assign sw          = {bus.i_Switch_4, bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};
    assign release_evt = prev_level & ~sw;
    assign start_grant = (state == IDLE) && (|pending);

    // Round-robin search starting just after the last grant; offset 4 wraps back to the last grant itself
    always_comb begin
        logic [1:0] idx;
        logic       found;
        winner = grant;
        found  = 1'b0;
        idx    = grant;
        for (int i = 1; i <= 4; i++) begin
            idx = grant + 2'(i);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Pending bit of the winner is cleared only on the grant edge
    always_comb begin
        clear_mask = 4'b0000;
        if (start_grant) begin
            clear_mask = 4'b0001 << winner;
        end
    end

    // Previous switch levels for falling-edge detection; cleared so a low switch after reset gives no event
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            prev_level <= 4'b0000;
        end else begin
            prev_level <= sw;
        end
    end

    // Queue release events; a new event beats a simultaneous grant clear, a repeat on a queued switch is dropped
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            pending <= 4'b0000;
            drop    <= 1'b0;
        end else begin
            pending <= (pending & ~clear_mask) | release_evt;
            if (|(release_evt & pending & ~clear_mask)) begin
                drop <= 1'b1;
            end
        end
    end

    // IDLE/HOLD/GAP sequencing with a shared timer that restarts on every state change
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            cnt      <= '0;
            grant    <= 2'd3;
            serviced <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_grant) begin
                        state <= HOLD;
                        grant <= winner;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state    <= GAP;
                        cnt      <= '0;
                        serviced <= serviced + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // One-hot LED of the current grant, only while holding
    always_comb begin
        led_mask = 4'b0000;
        if (state == HOLD) begin
            led_mask = 4'b0001 << grant;
        end
    end

    assign bus.o_LED_1    = led_mask[0];
    assign bus.o_LED_2    = led_mask[1];
    assign bus.o_LED_3    = led_mask[2];
    assign bus.o_LED_4    = led_mask[3];
    assign bus.o_Busy     = (state == HOLD) || (state == GAP);
    assign bus.o_Grant    = grant;
    assign bus.o_Drop     = drop;
    assign bus.o_Serviced = serviced;
endmodule

// File: tb/tb_switch_event_arbiter.sv
// tb/tb_switch_event_arbiter.sv - randomized bench against a slot-timeline reference model
module tb_switch_event_arbiter;
    localparam int H = 4;
    localparam int G = 2;

    logic i_Clk;
    logic i_Rst_L;

    switch_event_arbiter_if bus ();

    switch_event_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .bus     (bus)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each grant owns a window of H+G busy cycles counted down in m_left
    bit m_prev [4];
    bit m_pend [4];
    int m_left;
    int m_grant;
    bit m_drop;
    int m_serv;
    bit sw [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int clr;
        int w;
        bit ev [4];
        clr = -1;
        if (!i_Rst_L) begin
            for (int n = 0; n < 4; n++) begin
                m_prev[n] = 0;
                m_pend[n] = 0;
            end
            m_left  = 0;
            m_grant = 3;
            m_drop  = 0;
            m_serv  = 0;
            return;
        end
        for (int n = 0; n < 4; n++) ev[n] = m_prev[n] && !sw[n];
        if (m_left == 0) begin
            for (int k = 1; k <= 4 && clr < 0; k++) begin
                w = (m_grant + k) % 4;
                if (m_pend[w]) clr = w;
            end
            if (clr >= 0) begin
                m_grant = clr;
                m_left  = H + G;
            end
        end else begin
            m_left--;
            if (m_left == G) m_serv = (m_serv + 1) % 256;
        end
        for (int n = 0; n < 4; n++) begin
            if (ev[n]) begin
                if (m_pend[n] && n != clr) m_drop = 1;
                m_pend[n] = 1;
            end else if (n == clr) begin
                m_pend[n] = 0;
            end
            m_prev[n] = sw[n];
        end
    endtask

    task automatic compare_all();
        logic [3:0] leds;
        logic [3:0] exp_leds;
        leds     = {bus.o_LED_4, bus.o_LED_3, bus.o_LED_2, bus.o_LED_1};
        exp_leds = (m_left > G) ? (4'b0001 << m_grant) : 4'b0000;
        check("leds",     32'(leds),           32'(exp_leds));
        check("busy",     32'(bus.o_Busy),     32'(m_left > 0));
        check("grant",    32'(bus.o_Grant),    32'(m_grant));
        check("drop",     32'(bus.o_Drop),     32'(m_drop));
        check("serviced", 32'(bus.o_Serviced), 32'(m_serv));
    endtask

    task automatic drive_sw();
        bus.i_Switch_1 = sw[0];
        bus.i_Switch_2 = sw[1];
        bus.i_Switch_3 = sw[2];
        bus.i_Switch_4 = sw[3];
    endtask

    task automatic tick();
        drive_sw();
        @(posedge i_Clk);
        model_edge();
        @(negedge i_Clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_all(input bit v);
        for (int n = 0; n < 4; n++) sw[n] = v;
    endtask

    task automatic do_reset();
        i_Rst_L = 1'b0;
        tick();
        tick();
        i_Rst_L = 1'b1;
    endtask

    initial begin
        i_Rst_L = 1'b0;
        set_all(0);
        drive_sw();
        for (int n = 0; n < 4; n++) begin
            m_prev[n] = 0;
            m_pend[n] = 0;
        end
        m_left = 0; m_grant = 0; m_drop = 0; m_serv = 0;
        do_reset();

        check("rst_grant", 32'(bus.o_Grant), 32'd3);
        check("rst_busy",  32'(bus.o_Busy),  32'd0);

        // Single release of switch 1: hold 4, gap 2, one serviced
        sw[0] = 1; ticks(3);
        sw[0] = 0; ticks(12);
        check("single_serv", 32'(bus.o_Serviced), 32'd1);

        // All four fall together after reset: serviced in order 1..4
        do_reset();
        set_all(1); ticks(2);
        set_all(0); ticks(40);
        check("all4_serv",  32'(bus.o_Serviced), 32'd4);
        check("all4_grant", 32'(bus.o_Grant),    32'd3);

        // Grant on switch 3 with 2 and 4 queued during its hold
        do_reset();
        sw[2] = 1; tick(); sw[2] = 0; tick();
        sw[1] = 1; sw[3] = 1; tick(); sw[1] = 0; sw[3] = 0; tick();
        ticks(8);
        check("rr_after3", 32'(bus.o_Grant), 32'd3);
        ticks(8);
        check("rr_then2",  32'(bus.o_Grant), 32'd1);
        ticks(10);

        // Switch 2 falls twice during switch 1's hold
        do_reset();
        sw[0] = 1; tick(); sw[0] = 0; tick();
        sw[1] = 1; tick(); sw[1] = 0; tick(); sw[1] = 1; tick(); sw[1] = 0; tick();
        ticks(20);
        check("drop_set",  32'(bus.o_Drop),     32'd1);
        check("drop_serv", 32'(bus.o_Serviced), 32'd2);

        // Reset mid-hold with requests queued: grant aborted, nothing further
        do_reset();
        sw[0] = 1; sw[1] = 1; sw[2] = 1; tick();
        set_all(0); ticks(3);
        i_Rst_L = 1'b0; tick(); i_Rst_L = 1'b1;
        check("abort_led",   32'({bus.o_LED_4, bus.o_LED_3, bus.o_LED_2, bus.o_LED_1}), 32'd0);
        ticks(20);
        check("abort_grant", 32'(bus.o_Grant),    32'd3);
        check("abort_serv",  32'(bus.o_Serviced), 32'd0);

        // Switch already high at reset release only fires when it falls
        i_Rst_L = 1'b0; sw[3] = 1; tick(); i_Rst_L = 1'b1;
        ticks(4);
        check("hi_norel", 32'(bus.o_Busy), 32'd0);
        sw[3] = 0; ticks(2);
        check("hi_fall",  32'(bus.o_LED_4), 32'd1);
        ticks(10);

        // 256 sequential single grants wrap the serviced counter
        do_reset();
        for (int g = 0; g < 256; g++) begin
            sw[g % 4] = 1; tick(); sw[g % 4] = 0; ticks(8);
        end
        ticks(4);
        check("wrap_serv", 32'(bus.o_Serviced), 32'd0);

        // Random switch activity with occasional resets
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, 7) == 0) sw[n] = ~sw[n];
            end
            i_Rst_L = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/switch_event_arbiter.md
SWITCH_EVENT_ARBITER -- requirements
Module: switch_event_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 12500000, number of cycles a granted LED SHALL stay lit (min 1).
REQ-002 Parameter GAP_CYCLES, default 2500000, number of dead cycles after each hold (min 1).
REQ-003 i_Clk  in  1  system clock; all state SHALL update on its rising edge only.
REQ-004 i_Rst_L  in  1  reset, synchronous, active-low.
REQ-005 i_Switch_1..i_Switch_4  in  1 each  debounced switch levels, already synchronous to i_Clk.
REQ-006 o_LED_1..o_LED_4  out  1 each  LED n SHALL be high only while switch n holds the grant.
REQ-007 o_Busy  out  1  SHALL be high in HOLD and GAP states.
REQ-008 o_Grant  out  2  index of last granted requester (0 = switch 1 ... 3 = switch 4).
REQ-009 o_Drop  out  1  sticky flag: a release event was lost.
REQ-010 o_Serviced  out  8  count of completed grants.

Function
REQ-011 Per switch, a previous-level register SHALL capture i_Switch_n every cycle.
REQ-012 A release event SHALL be detected on the edge where i_Switch_n = 0 and the previous-level register = 1.
REQ-013 A detected event SHALL set pending[n] on that same edge.
REQ-014 An event on a switch whose pending bit is already set SHALL be discarded and SHALL set o_Drop.
REQ-015 An event on switch n on the edge pending[n] is being cleared by a grant SHALL leave pending[n] set (set wins).
REQ-016 The FSM SHALL have states IDLE, HOLD and GAP.
REQ-017 IDLE -> HOLD SHALL occur on the first edge in IDLE where any pending bit is set.
REQ-018 On the IDLE -> HOLD edge, the winner's pending bit SHALL clear and o_Grant SHALL load the winner index.
REQ-019 Winner selection SHALL be round-robin: search from (o_Grant+1) mod 4 upward, wrapping, first set pending bit wins.
REQ-020 In HOLD, exactly the LED of o_Grant SHALL be high, for exactly HOLD_CYCLES cycles.
REQ-021 HOLD -> GAP SHALL occur after HOLD_CYCLES cycles; in GAP all LEDs SHALL be low.
REQ-022 GAP -> IDLE SHALL occur after GAP_CYCLES cycles.
REQ-023 IDLE SHALL last at least one cycle between grants.
REQ-024 Latency: an event detected on edge E0 while IDLE and no other pending bit set SHALL give LED high from edge E0+1.
REQ-025 Events detected during HOLD or GAP SHALL be queued in their pending bits and not lost, except per REQ-014.
REQ-026 o_Serviced SHALL increment by 1 on each HOLD -> GAP edge and wrap 255 -> 0.
REQ-027 The hold/gap counter SHALL be sized by clog2 of the larger parameter and reload to 0 on every state change.
REQ-028 At most one LED SHALL be high in any cycle.

Reset
REQ-029 While i_Rst_L = 0 at an edge, the block SHALL set: state IDLE, pending 0, previous-level registers 0, counter 0.
REQ-030 Reset SHALL also set: o_Grant = 3 (so switch 1 wins first), o_Drop = 0, o_Serviced = 0, all LEDs 0, o_Busy 0.
REQ-031 Reset asserted mid-HOLD or mid-GAP SHALL abort the grant; queued events SHALL be discarded.
REQ-032 After reset release, a switch already low SHALL NOT generate an event.
REQ-033 After reset release, a switch already high SHALL generate an event only when it next falls.

Verification (bench uses HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-034 Switch 1 high 3 cycles then low at edge E0 -> o_LED_1 high edges E0+1..E0+4, o_Busy high E0+1..E0+6, o_Serviced = 1.
REQ-035 Switches 1..4 fall on the same edge after reset -> LEDs light in order 1,2,3,4, each 4 cycles, 2-cycle gaps plus 1 IDLE cycle between, o_Serviced = 4.
REQ-036 Grant at switch 3, switches 2 and 4 pending -> next grant is switch 4, then switch 2.
REQ-037 Switch 2 falls twice during switch 1's HOLD -> o_Drop = 1, switch 2 serviced exactly once.
REQ-038 i_Rst_L low for 1 cycle mid-HOLD with other requests pending -> all LEDs 0 next edge, no further grants, o_Grant = 3.
REQ-039 256 sequential single grants -> o_Serviced wraps to 0.
